// File: rtl/negate_serial.sv
// negate_serial: bit-serial two's-complement negation (-In = ~In + 1).
// The operand is processed LSB-first, one bit per clock. Bits are copied
// up to and including the first 1; every bit after that is inverted.
// Valid/ready handshakes on the input and output sides.
module negate_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] In,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             seen_one;
   logic             b;
   logic             obit;

   // Current serial bit and its output value under the copy-until-first-one rule
   always_comb begin
      b    = shreg[0];
      obit = seen_one ? ~b : b;
   end

   // Control FSM, serial datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         shreg     <= '0;
         acc       <= '0;
         cnt       <= '0;
         seen_one  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg    <= In;
                  acc      <= '0;
                  cnt      <= '0;
                  seen_one <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               shreg    <= shreg >> 1;
               acc      <= {obit, acc[WIDTH-1:1]};
               seen_one <= seen_one | b;
               if (cnt == CW'(WIDTH - 1)) begin
                  // Last bit: publish the completed accumulator and flags.
                  // ovf means the only 1 seen is the MSB (most-negative value).
                  out       <= {obit, acc[WIDTH-1:1]};
                  zero      <= ~(seen_one | b);
                  ovf       <= ~seen_one & b;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_negate_serial.sv
// Self-checking bench for negate_serial: directed cases, backpressure,
// asynchronous mid-operation reset and a randomized regression against
// an arithmetic reference ((-In) mod 2^16).
module tb_negate_serial;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] In;
   logic [W-1:0] out;
   logic         out_valid;
   logic         out_ready;
   logic         ovf;
   logic         zero;

   int nassert = 0;
   int nfail   = 0;

   negate_serial #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .In        (In),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; sample point is 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference model: plain modular arithmetic on the operand
   function automatic logic [W-1:0] ref_neg(input logic [W-1:0] v);
      int unsigned x;
      x = (32'd65536 - 32'(v)) % 32'd65536;
      return W'(x);
   endfunction

   // present operand, wait for acceptance, wait for result, check it
   task automatic start_op(input logic [W-1:0] v, input bit chk_lat, input bit rnd_ready);
      int n;
      in_valid = 1'b1;
      In       = v;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check("accept_timeout", 32'(n < 50), 32'd1);
      step();                       // acceptance edge
      in_valid = 1'b0;
      In       = W'($urandom);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      if (chk_lat) begin
         repeat (W - 1) step();
         check("lat_not_yet", 32'(out_valid), 32'd0);
         step();
         check("lat_valid", 32'(out_valid), 32'd1);
      end else begin
         n = 0;
         while (!out_valid && n < 60) begin
            out_ready = rnd_ready ? 1'($urandom) : 1'b0;
            step();
            n++;
         end
         out_ready = 1'b0;
         check("result_timeout", 32'(out_valid), 32'd1);
      end
      check("out", 32'(out), 32'(ref_neg(v)));
      check("ovf", 32'(ovf), 32'(v == 16'h8000));
      check("zero", 32'(zero), 32'(v == 16'h0000));
      check("in_ready_done", 32'(in_ready), 32'd0);
   endtask

   // hold the result for 'hold' cycles, then complete the output handshake
   task automatic finish_op(input int hold, input logic [W-1:0] v);
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_out", 32'(out), 32'(ref_neg(v)));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] dir [6];
      dir = '{16'h0001, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      In        = '0;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      check("rst_flags", {30'd0, ovf, zero}, 32'd0);
      step();
      rst = 1'b0;

      // directed operands with exact latency check
      foreach (dir[i]) begin
         start_op(dir[i], 1'b1, 1'b0);
         finish_op(0, dir[i]);
      end

      // backpressure: result held, new operand offered but must be ignored
      start_op(16'h1234, 1'b1, 1'b0);
      in_valid = 1'b1;
      In       = 16'h0005;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_out", 32'(out), 32'h0000EDCC);
         check("bp_flags", {30'd0, ovf, zero}, 32'd0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      finish_op(0, 16'h1234);
      start_op(16'h0005, 1'b1, 1'b0);
      check("bp_next", 32'(out), 32'h0000FFFB);
      finish_op(0, 16'h0005);

      // asynchronous reset after the 7th shift cycle
      in_valid = 1'b1;
      In       = 16'h00F0;
      step();                       // acceptance edge
      in_valid = 1'b0;
      repeat (7) step();
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out", 32'(out), 32'd0);
      check("arst_flags", {30'd0, ovf, zero}, 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      start_op(16'h0002, 1'b1, 1'b0);
      check("arst_next", 32'(out), 32'h0000FFFE);
      finish_op(0, 16'h0002);

      // randomized regression
      for (int k = 0; k < 1000; k++) begin
         v = W'($urandom);
         if (k % 50 == 0) v = 16'h8000;
         if (k % 50 == 25) v = 16'h0000;
         repeat ($urandom_range(0, 3)) step();
         start_op(v, 1'b0, 1'b1);
         finish_op(int'($urandom_range(0, 3)), v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

   // global watchdog so the bench always terminates
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/negate_serial.md
# negate_serial

Bit-serial two's-complement negation unit for the 16-bit ALU datapath. It is the arithmetic counterpart of the bitwise-invert path: it produces −In = ~In + 1 with no parallel adder. The operand is processed LSB-first, one bit per clock, using the copy-until-first-one rule. A valid/ready handshake sits on each side, so the unit can be placed between the operand register and the ALU result mux and can tolerate a stalled consumer.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand on In is valid
- in_ready  output  1  unit can accept an operand (high only in IDLE)
- In  input  WIDTH  operand, two's complement
- out  output  WIDTH  negated result, registered
- out_valid  output  1  out/ovf/zero are valid
- out_ready  input  1  consumer accepts result
- ovf  output  1  operand was the most-negative value (1 followed by WIDTH−1 zeros); result equals operand
- zero  output  1  result is zero (operand was 0)

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clock edge with in_valid=1, the unit loads In into the shift register, clears bit counter cnt to 0, clears seen_one, and goes to SHIFT.
- SHIFT (in_ready=0, out_valid=0), once per clock:
  - b = shreg[0].
  - obit = seen_one ? ~b : b.
  - seen_one ← seen_one | b.
  - shreg shifts right by 1.
  - The accumulator shifts right with obit entering at the MSB.
  - cnt increments.
  - On the edge that processes bit WIDTH−1, the unit transfers the accumulator to out and goes to DONE.
- Flags are computed during the shift and registered at DONE entry:
  - zero=1 iff no 1 bit was seen.
  - ovf=1 iff the only 1 bit seen was bit WIDTH−1.
- DONE:
  - out_valid=1. out, ovf and zero are held stable.
  - On an edge with out_ready=1, the unit goes to IDLE and out_valid drops.
  - out, ovf and zero keep their last values until the next DONE entry.
- Ignored inputs:
  - in_valid outside IDLE is ignored; the operand is not queued.
  - out_ready outside DONE is ignored.
- Arithmetic is modulo 2^WIDTH. No carry-out is produced.
- cnt width is clog2(WIDTH). It never wraps past WIDTH−1.

## Timing
- Reset values (asserted asynchronously, no clock needed):
  - state=IDLE, in_ready=1, out_valid=0, out=0, ovf=0, zero=0.
  - shreg, accumulator, cnt and seen_one are cleared.
- Latency: operand accepted on edge E0 → SHIFT on edges E1..E16 (WIDTH=16) → out_valid=1 after E16, i.e. WIDTH cycles after acceptance.
- Throughput: one result per WIDTH+2 cycles at best. There is no back-to-back overlap: the minimum is one DONE cycle with out_ready=1 and one IDLE accept cycle.
- out_valid stays high indefinitely while out_ready=0. There is no timeout.
- An out_ready held high continuously completes the handshake on the first DONE edge.
- Reset in mid-operation (any state) aborts immediately:
  - The partial result is discarded.
  - Outputs go to their reset values.
  - in_ready=1 after release.
- Deassertion of rst is assumed synchronous to clk at the system level. On the first edge after release, the unit may accept an operand.
- All outputs are registered or decoded from state only. There is no combinational path from In/in_valid/out_ready to any output.

## Test plan
- Accept In=0x0001 → after 16 cycles out_valid=1, out=0xFFFF, ovf=0, zero=0; out_ready=1 → IDLE, in_ready=1 on the next cycle.
- In=0x1234 → out=0xEDCC. In=0xFFFF → out=0x0001. In=0x7FFF → out=0x8001. All have flags 0.
- In=0x0000 → out=0x0000, zero=1, ovf=0. In=0x8000 → out=0x8000, ovf=1, zero=0.
- Backpressure: result 0xEDCC present, hold out_ready=0 for 5 cycles while driving in_valid=1 with In=0x0005 → out/flags stable, in_ready=0, 0x0005 not consumed. Release → IDLE; the next accept of 0x0005 yields 0xFFFB.
- Assert rst asynchronously after the 7th SHIFT cycle of In=0x00F0 → out_valid=0, out=0, ovf=0, zero=0, in_ready=1 without a clock edge. A following operand 0x0002 yields 0xFFFE with correct latency.
- Random regression: 1000 operands with random in_valid/out_ready gaps → every out equals (−In) mod 2^16, flags match, and no operand is lost or duplicated.
